core_scheduler: RTL and testbench

- Per-core control FSM that sequences one instruction at a time through FETCH, DECODE, REQUEST, WAIT, EXECUTE and UPDATE for all thread lanes of a core.
- Gates when the per-thread register files and ALUs may sample or commit results by broadcasting core_state to them.
- Stalls the core while the instruction fetcher or any enabled thread's LSU is busy.
- Owns the shared program counter and the core's done flag.

---
 rtl/core_scheduler.sv | 173 +++++++++++++++++
 tb/tb_core_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : core_scheduler
// Description : Per-core control FSM. Runs one instruction at a time through
//               FETCH -> DECODE -> REQUEST -> WAIT -> EXECUTE -> UPDATE for
//               every thread lane of the core. It broadcasts core_state so the
//               register files, ALUs and LSUs know when to sample or commit.
//               It also owns the shared PC and the sticky done/diverged flags.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk               clock
//   reset             synchronous, active-high reset
//   i_start           level; begin execution from PC 0
//   i_thread_enable   lane i active when bit i = 1 (sampled every cycle)
//   i_fetcher_state   0=IDLE 1=FETCHING 2=FETCHED (others = not fetched)
//   i_decoded_ret     decoded instruction is RET (valid from DECODE onward)
//   i_lsu_state       per-lane LSU state, lane i at [2i+1:2i]
//   i_next_pc         per-lane next PC, lane i at [PC_BITS*(i+1)-1:PC_BITS*i]
//   o_core_state      0=IDLE 1=FETCH 2=DECODE 3=REQUEST 4=WAIT 5=EXECUTE
//                     6=UPDATE 7=DONE
//   o_current_pc      PC of the instruction in flight
//   o_done            kernel finished on this core (sticky)
//   o_diverged        lanes disagreed on next PC (sticky)
// ============================================================================
module core_scheduler #(
  parameter int THREADS = 4,
  parameter int PC_BITS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_start,
  input  logic [THREADS-1:0]         i_thread_enable,
  input  logic [2:0]                 i_fetcher_state,
  input  logic                       i_decoded_ret,
  input  logic [2*THREADS-1:0]       i_lsu_state,
  input  logic [PC_BITS*THREADS-1:0] i_next_pc,
  output logic [2:0]                 o_core_state,
  output logic [PC_BITS-1:0]         o_current_pc,
  output logic                       o_done,
  output logic                       o_diverged
);

  localparam logic [2:0] c_FETCHED    = 3'd2;
  localparam logic [1:0] c_LSU_REQ    = 2'd1;
  localparam logic [1:0] c_LSU_WAIT   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_REQUEST = 3'd3,
    S_WAIT    = 3'd4,
    S_EXECUTE = 3'd5,
    S_UPDATE  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PC_BITS-1:0]   r_pc;
  logic [PC_BITS-1:0]   w_pc_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 r_diverged;
  logic                 w_diverged_nxt;

  logic                 w_busy;
  logic                 w_lead_found;
  logic [PC_BITS-1:0]   w_lead_pc;
  logic                 w_pc_mismatch;

  // Lane scan: memory busy over enabled lanes, and the PC proposed by the
  // lowest-index enabled lane (the lane the core follows on divergence).
  always_comb begin
    w_busy       = 1'b0;
    w_lead_found = 1'b0;
    w_lead_pc    = '0;
    for (int i = 0; i < THREADS; i++) begin
      if (i_thread_enable[i]) begin
        if ((i_lsu_state[2*i +: 2] == c_LSU_REQ) ||
            (i_lsu_state[2*i +: 2] == c_LSU_WAIT)) begin
          w_busy = 1'b1;
        end
        if (!w_lead_found) begin
          w_lead_found = 1'b1;
          w_lead_pc    = i_next_pc[PC_BITS*i +: PC_BITS];
        end
      end
    end
  end

  // Any enabled lane that disagrees with the lead lane marks divergence.
  always_comb begin
    w_pc_mismatch = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (i_thread_enable[i] &&
          (i_next_pc[PC_BITS*i +: PC_BITS] != w_lead_pc)) begin
        w_pc_mismatch = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_done_nxt     = r_done;
    w_diverged_nxt = r_diverged;
    case (r_state)
      S_IDLE: begin
        w_pc_nxt = '0;
        if (i_start) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (i_fetcher_state == c_FETCHED) begin
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE:  w_state_nxt = S_REQUEST;
      S_REQUEST: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (!w_busy) begin
          w_state_nxt = S_EXECUTE;
        end
      end
      S_EXECUTE: w_state_nxt = S_UPDATE;
      S_UPDATE: begin
        if (i_decoded_ret) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_FETCH;
          if (w_lead_found) begin
            w_pc_nxt = w_lead_pc;
            if (w_pc_mismatch) begin
              w_diverged_nxt = 1'b1;
            end
          end else begin
            // No lane enabled: step sequentially, wrapping at the PC width.
            w_pc_nxt = r_pc + 1'b1;
          end
        end
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_done     <= 1'b0;
      r_diverged <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_done     <= w_done_nxt;
      r_diverged <= w_diverged_nxt;
    end
  end

  assign o_core_state = r_state;
  assign o_current_pc = r_pc;
  assign o_done       = r_done;
  assign o_diverged   = r_diverged;

endmodule
`default_nettype wire

// File: tb/tb_core_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_scheduler
// Description : Self-checking bench for core_scheduler. A behavioural model
//               tracks the expected outputs every cycle; directed sequences
//               carry hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_scheduler;

  localparam int T  = 4;
  localparam int PB = 8;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [T-1:0]  te    = 4'hF;
  logic [2:0]    fs    = 3'd0;
  logic          ret   = 1'b0;
  logic [2*T-1:0] lsu  = '0;
  logic [PB*T-1:0] np  = '0;

  logic [2:0]    o_core_state;
  logic [PB-1:0] o_current_pc;
  logic          o_done;
  logic          o_diverged;

  core_scheduler #(.THREADS(T), .PC_BITS(PB)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_start         (start),
    .i_thread_enable (te),
    .i_fetcher_state (fs),
    .i_decoded_ret   (ret),
    .i_lsu_state     (lsu),
    .i_next_pc       (np),
    .o_core_state    (o_core_state),
    .o_current_pc    (o_current_pc),
    .o_done          (o_done),
    .o_diverged      (o_diverged)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_state = 0;
  int m_pc    = 0;
  int m_done  = 0;
  int m_div   = 0;
  bit m_valid = 1'b0;

  function automatic bit model_busy();
    for (int i = 0; i < T; i++) begin
      if (te[i] && (lsu[2*i +: 2] == 2'd1 || lsu[2*i +: 2] == 2'd2)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // PCs proposed by enabled lanes, lowest index first.
  function automatic void enabled_pcs(output int q[$]);
    q = {};
    for (int i = 0; i < T; i++) begin
      if (te[i]) q.push_back(int'(np[PB*i +: PB]));
    end
  endfunction

  always @(posedge clk) begin
    int q[$];
    if (reset) begin
      m_state <= 0;
      m_pc    <= 0;
      m_done  <= 0;
      m_div   <= 0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      case (m_state)
        0: if (start) m_state <= 1;
        1: if (fs == 3'd2) m_state <= 2;
        2: m_state <= 3;
        3: m_state <= 4;
        4: if (!model_busy()) m_state <= 5;
        5: m_state <= 6;
        6: begin
          if (ret) begin
            m_done  <= 1;
            m_state <= 7;
          end else begin
            m_state <= 1;
            enabled_pcs(q);
            if (q.size() == 0) begin
              m_pc <= (m_pc + 1) % (1 << PB);
            end else begin
              m_pc <= q[0];
              foreach (q[k]) if (q[k] != q[0]) m_div <= 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_state",    int'(o_core_state), m_state);
      chk("model_pc",       int'(o_current_pc), m_pc);
      chk("model_done",     int'(o_done),       m_done);
      chk("model_diverged", int'(o_diverged),   m_div);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input string name, input int exp_state);
    step();
    chk(name, int'(o_core_state), exp_state);
  endtask

  // One plain instruction from FETCH with a 1-cycle fetch and no memory stall.
  task automatic run_plain(input string name);
    fs = 3'd2; go({name, "_dec"}, 2);
    fs = 3'd0; go({name, "_req"}, 3);
    go({name, "_wait"}, 4);
    go({name, "_exe"},  5);
    go({name, "_upd"},  6);
    go({name, "_fetch"}, 1);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    step(); step();
    chk("rst_state", int'(o_core_state), 0);
    chk("rst_pc",    int'(o_current_pc), 0);
    chk("rst_done",  int'(o_done),       0);
    chk("rst_div",   int'(o_diverged),   0);

    // T1: basic sequence with a 2-cycle fetch
    reset = 1'b0;
    te    = 4'hF;
    lsu   = '0;
    np    = {4{8'h01}};
    start = 1'b1;
    go("t1_fetch", 1);
    start = 1'b0;
    fs = 3'd1; go("t1_fetch_hold", 1);
    fs = 3'd2; go("t1_decode", 2);
    fs = 3'd0; go("t1_request", 3);
    go("t1_wait", 4);
    go("t1_execute", 5);
    go("t1_update", 6);
    go("t1_refetch", 1);
    chk("t1_pc",   int'(o_current_pc), 1);
    chk("t1_done", int'(o_done), 0);

    // T2: lane 2 stalls WAIT for 5 cycles
    fs = 3'd2; go("t2_decode", 2);
    fs = 3'd0; go("t2_request", 3);
    lsu = 8'h20;
    go("t2_wait_enter", 4);
    for (int k = 0; k < 4; k++) go("t2_wait_stall", 4);
    lsu = 8'h30;
    np  = {4{8'h02}};
    go("t2_execute", 5);
    go("t2_update", 6);
    go("t2_refetch", 1);
    chk("t2_pc", int'(o_current_pc), 2);
    lsu = '0;

    // T3: disabled lane 2 stuck busy is ignored; lane 0 supplies the PC
    te  = 4'b1011;
    lsu = 8'h10;
    np  = {8'h05, 8'h09, 8'h05, 8'h05};
    fs = 3'd2; go("t3_decode", 2);
    fs = 3'd0; go("t3_request", 3);
    go("t3_wait", 4);
    go("t3_wait_exit", 5);
    go("t3_update", 6);
    go("t3_refetch", 1);
    chk("t3_pc",  int'(o_current_pc), 5);
    chk("t3_div", int'(o_diverged), 0);
    te  = 4'hF;
    lsu = '0;

    // Move to PC 7 for the RET test
    np = {4{8'h07}};
    run_plain("pc7");
    chk("pc7_pc", int'(o_current_pc), 7);

    // T4: RET finishes the kernel; DONE absorbs start toggles
    fs = 3'd2; go("t4_decode", 2);
    fs = 3'd0;
    ret = 1'b1;
    go("t4_request", 3);
    go("t4_wait", 4);
    go("t4_execute", 5);
    go("t4_update", 6);
    go("t4_done_state", 7);
    chk("t4_done", int'(o_done), 1);
    chk("t4_pc",   int'(o_current_pc), 7);
    ret = 1'b0;
    for (int k = 0; k < 4; k++) begin
      start = ~start;
      step();
      chk("t4_hold_state", int'(o_core_state), 7);
      chk("t4_hold_pc",    int'(o_current_pc), 7);
      chk("t4_hold_done",  int'(o_done), 1);
    end
    start = 1'b0;

    // T5: divergence follows lane 0 and is sticky; PC wraps with no lanes
    reset = 1'b1; step(); reset = 1'b0;
    chk("t5_rst_state", int'(o_core_state), 0);
    chk("t5_rst_done",  int'(o_done), 0);
    start = 1'b1; go("t5_fetch", 1); start = 1'b0;
    np = {8'h10, 8'h10, 8'h20, 8'h10};
    run_plain("t5a");
    chk("t5_pc_lead", int'(o_current_pc), 16);
    chk("t5_div_set", int'(o_diverged), 1);
    np = {4{8'hFF}};
    run_plain("t5b");
    chk("t5_pc_ff",     int'(o_current_pc), 255);
    chk("t5_div_stick", int'(o_diverged), 1);
    te = 4'h0;
    run_plain("t5c");
    chk("t5_pc_wrap",   int'(o_current_pc), 0);
    chk("t5_div_keep",  int'(o_diverged), 1);
    te = 4'hF;

    // T6: reset in the middle of a memory stall
    fs = 3'd2; go("t6_decode", 2);
    fs = 3'd0; go("t6_request", 3);
    lsu = 8'h01;
    go("t6_wait", 4);
    go("t6_wait_stall", 4);
    reset = 1'b1;
    step();
    chk("t6_state", int'(o_core_state), 0);
    chk("t6_pc",    int'(o_current_pc), 0);
    chk("t6_done",  int'(o_done), 0);
    chk("t6_div",   int'(o_diverged), 0);
    reset = 1'b0;
    lsu   = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
